// File: rtl/right_arith_shift_seq_if.sv
// Start/busy/done handshake and operand/result bus for the sequential arithmetic right shifter.
interface right_arith_shift_seq_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) ();
  logic             start;
  logic [WIDTH-1:0] A;
  logic [SHW-1:0]   SHAMT;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Y;
  logic             LOST;

  modport master (
    output start, A, SHAMT,
    input  busy, done, Y, LOST
  );

  modport slave (
    input  start, A, SHAMT,
    output busy, done, Y, LOST
  );
endinterface

// File: rtl/right_arith_shift_seq.sv
// Multi-cycle arithmetic right shifter: one bit per clock with sign fill,
// flags any 1 bit shifted out of bit 0 as LOST.
module right_arith_shift_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  right_arith_shift_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sr;
  logic [SHW-1:0]   r_cnt;
  logic             r_lacc;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_y;
  logic             r_lost;

  logic [WIDTH-1:0] w_sr_next;
  logic             w_lost_next;

  // One-position sign-replicating shift and running OR of the bits leaving bit 0.
  assign w_sr_next   = {r_sr[WIDTH-1], r_sr[WIDTH-1:1]};
  assign w_lost_next = r_lacc | r_sr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_lacc  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_y     <= '0;
      r_lost  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_sr   <= bus.A;
            r_cnt  <= bus.SHAMT;
            r_lacc <= 1'b0;
            r_busy <= 1'b1;
            if (bus.SHAMT != SHW'(0)) begin
              r_state <= S_SHIFT;
            end else begin
              // Zero shift completes immediately with the operand unchanged.
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_y     <= bus.A;
              r_lost  <= 1'b0;
            end
          end
        end

        S_SHIFT: begin
          r_sr   <= w_sr_next;
          r_lacc <= w_lost_next;
          r_cnt  <= r_cnt - SHW'(1);
          if (r_cnt == SHW'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_y     <= w_sr_next;
            r_lost  <= w_lost_next;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.Y    = r_y;
  assign bus.LOST = r_lost;

  // Handshake invariants: busy mirrors the state, done is a single-cycle pulse inside busy.
  a_busy_state : assert property (@(posedge clk) disable iff (rst)
    r_busy == (r_state != S_IDLE));
  a_done_busy : assert property (@(posedge clk) disable iff (rst)
    r_done |-> r_busy);
  a_done_pulse : assert property (@(posedge clk) disable iff (rst)
    r_done |=> !r_done);

endmodule
